pad_ext_pipe: RTL and testbench
===============================

// Module: pad_ext_pipe
// PURPOSE
//  Multi-channel, pipelined width converter; parametrised successor to the unsigned pad helper.
//  Each of CHANNELS lanes converts IN_W bits to OUT_W bits in one of three modes:
//  zero-extend, sign-extend, or signed saturate when narrowing. Conversion is selected per beat.
//  Sits between ext-module result buses and downstream consumers, with a valid/ready handshake.
//  A two-entry skid buffer keeps full throughput under backpressure.
// PARAMETERS
//  CHANNELS  2    number of independent lanes, >=1
//  IN_W      10   input lane width, >=1
//  OUT_W     16   output lane width, >=1; may be <, = or > IN_W
//  CNT_W     16   width of the saturating-event counter
// PORTS
//  clock       in   1               rising-edge clock
//  reset       in   1               asynchronous, active-low reset (asserted when 0)
//  in_valid    in   1               input beat valid
//  in_ready    out  1               block can accept a beat
//  in_data     in   CHANNELS*IN_W   lane k = in_data[k*IN_W +: IN_W]
//  in_mode     in   2               0 zero-extend, 1 sign-extend, 2 signed-saturate, 3 = treated as 0
//  out_valid   out  1               output beat valid
//  out_ready   in   1               consumer accepts beat
//  out_data    out  CHANNELS*OUT_W  converted lanes, same packing
//  out_sat     out  CHANNELS        per-lane flag: value was clipped or truncated-changed
//  sat_count   out  CNT_W           number of accepted beats with any out_sat bit set; saturates at all-ones
// BEHAVIOUR
//  Reset (async assert, sync deassert outside block): out_valid=0, out_data=0, out_sat=0, sat_count=0,
//   skid buffer empty, so in_ready=1 on the first clock after release.
//  Handshake: transfer on in_valid&in_ready, or on out_valid&out_ready; data is stable while out_valid&!out_ready.
//  Latency: 1 cycle from input transfer to out_valid when the pipe is empty.
//  Skid: main reg + skid reg. in_ready = !skid_full, registered, no comb path from out_ready.
//   If input is accepted while the main reg is held: store in skid, skid_full=1.
//   On the next out transfer: skid moves to main and skid_full clears.
//   Simultaneous in and out transfer with skid empty: main reloads with new beat, no bubble.
//  Conversion per lane, evaluated at input acceptance with the in_mode of that beat:
//   OUT_W>=IN_W, mode 0/3: {zeros, x}; mode 1 or 2: {sign copies, x}; out_sat=0.
//   OUT_W<IN_W, mode 0/1/3: keep low OUT_W bits; out_sat=1 if the discarded bits differ from
//    zero-extension (mode 0/3) or sign-extension (mode 1).
//   OUT_W<IN_W, mode 2: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; out_sat=1 when clamped.
//  sat_count increments by 1 per out transfer whose out_sat!=0; holds at 2^CNT_W-1.
//  Reset mid-operation clears all stored beats; in-flight data is dropped and no output is generated.
//  in_data and in_mode are don't-care when in_valid=0. out_data is unchanged while out_valid=0.
// STRUCTURE
//  pad_pkg: typedef enum logic[1:0] pad_mode_e {PAD_ZERO, PAD_SIGN, PAD_SAT, PAD_RSVD};
//   function automatic pad_lane conversion width helpers.
//  Sub-module pad_lane #(IN_W,OUT_W): combinational per-lane convert + sat flag, generated CHANNELS times.
//  Top level holds the skid/main registers, handshake logic and sat_count.
// TESTING
//  1. Defaults, mode 0, lane0=10'h3E8, lane1=10'h001, out_ready=1 -> next cycle out_data={16'h0001,16'h03E8}, out_sat=0.
//  2. Mode 1, lane0=10'h3E8 -> 16'hFFE8, out_sat=0. Mode 3, same input -> 16'h03E8.
//  3. OUT_W=8, mode 2, lane0=10'h1F4 (+500) -> 8'h7F, sat=1; lane1=10'h3F0 (-16) -> 8'hF0, sat=0; sat_count=1.
//  4. Stream 4 beats while out_ready=0 after beat 1 -> in_ready drops after beat 2.
//     Release out_ready -> beats emerge in order, no loss or duplication, full rate.
//  5. sat_count with CNT_W=2, 5 saturating beats -> sat_count holds at 3.
//  6. Assert reset with both registers full -> out_valid=0, sat_count=0 immediately (async).
//     in_ready=1 after release; no stale beat is emitted.

Source files
------------

// File: rtl/pad_ext_pipe_pkg.sv
// pad_ext_pipe_pkg
//   Shared types and helpers for the pad_ext_pipe width converter.
//   pad_mode_e : per-beat conversion mode carried alongside the data.
//   mode_signed: true when the input lane is treated as two's complement.
//   mode_clamp : true when narrowing clamps instead of truncating.
package pad_ext_pipe_pkg;

  typedef enum logic [1:0] {
    PAD_ZERO = 2'd0,
    PAD_SIGN = 2'd1,
    PAD_SAT  = 2'd2,
    PAD_RSVD = 2'd3   // behaves exactly like PAD_ZERO
  } pad_mode_e;

  function automatic logic mode_signed(pad_mode_e m);
    return (m == PAD_SIGN) || (m == PAD_SAT);
  endfunction

  function automatic logic mode_clamp(pad_mode_e m);
    return (m == PAD_SAT);
  endfunction

endpackage

// File: rtl/pad_ext_pipe_if.sv
// pad_ext_pipe_if
//   Input and output valid/ready streams of pad_ext_pipe bundled together.
//   Lane k of in_data is in_data[k*IN_W +: IN_W]; out_data uses the same
//   packing with OUT_W-bit lanes and out_sat carries one flag per lane.
//   master: producer/consumer side (testbench or surrounding logic).
//   slave : the converter itself.
interface pad_ext_pipe_if
  import pad_ext_pipe_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int IN_W     = 10,
  parameter int OUT_W    = 16
);
  logic                      in_valid;
  logic                      in_ready;
  logic [CHANNELS*IN_W-1:0]  in_data;
  pad_mode_e                 in_mode;
  logic                      out_valid;
  logic                      out_ready;
  logic [CHANNELS*OUT_W-1:0] out_data;
  logic [CHANNELS-1:0]       out_sat;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/pad_ext_pipe_lane.sv
// pad_lane
//   Combinational conversion of one IN_W-bit lane to OUT_W bits.
//   Ports: x (input lane), mode (conversion mode), y (converted lane),
//          sat (value was clamped, or truncation changed its meaning).
//   Widening/equal: zero or sign extension, never flags.
//   Narrowing     : truncate (zero/sign/reserved) or clamp (saturate).
module pad_lane
  import pad_ext_pipe_pkg::*;
#(
  parameter int IN_W  = 10,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  x,
  input  pad_mode_e        mode,
  output logic [OUT_W-1:0] y,
  output logic             sat
);

  generate
    if (OUT_W > IN_W) begin : g_wide
      logic sgn;
      always_comb begin
        sgn = mode_signed(mode) & x[IN_W-1];
        y   = {{(OUT_W-IN_W){sgn}}, x};
        sat = 1'b0;
      end
    end else if (OUT_W == IN_W) begin : g_same
      always_comb begin
        y   = x;
        sat = 1'b0 & mode_signed(mode);
      end
    end else begin : g_narrow
      localparam int DW = IN_W - OUT_W;
      logic [DW-1:0]    hi;
      logic [OUT_W-1:0] lo;
      logic [OUT_W-1:0] smax;
      logic             fits_u;
      logic             fits_s;

      always_comb begin
        hi     = x[IN_W-1:OUT_W];
        lo     = x[OUT_W-1:0];
        // Value fits unsigned iff dropped bits are zero; fits signed iff the
        // dropped bits are all copies of the kept sign bit.
        fits_u = (hi == '0);
        fits_s = (hi == {DW{lo[OUT_W-1]}});
        smax   = '1;
        smax[OUT_W-1] = 1'b0;
        y      = lo;
        sat    = 1'b0;
        if (mode_clamp(mode)) begin
          if (!fits_s) begin
            sat = 1'b1;
            y   = x[IN_W-1] ? ~smax : smax;   // ~smax is the most negative code
          end
        end else if (mode_signed(mode)) begin
          sat = !fits_s;
        end else begin
          sat = !fits_u;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/pad_ext_pipe.sv
// pad_ext_pipe
//   Multi-lane pipelined width converter with a two-entry skid buffer.
//   Ports:
//     clock     : rising-edge clock
//     reset     : asynchronous active-low reset
//     bus       : slave side of pad_ext_pipe_if (in/out valid-ready streams)
//     sat_count : accepted output beats with any out_sat bit, saturating
//   Conversion happens at input acceptance; the converted beat lands in the
//   main register (1-cycle latency) or, if main is stalled, in the skid
//   register. in_ready is simply !skid_full, so it is a flop output.
module pad_ext_pipe
  import pad_ext_pipe_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int IN_W     = 10,
  parameter int OUT_W    = 16,
  parameter int CNT_W    = 16
) (
  input  logic              clock,
  input  logic              reset,
  pad_ext_pipe_if.slave     bus,
  output logic [CNT_W-1:0]  sat_count
);

  logic [CHANNELS-1:0][OUT_W-1:0] conv_data;
  logic [CHANNELS-1:0]            conv_sat;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    pad_lane #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
    ) u_lane (
      .x    (bus.in_data[k*IN_W +: IN_W]),
      .mode (bus.in_mode),
      .y    (conv_data[k]),
      .sat  (conv_sat[k])
    );
  end

  logic [CHANNELS-1:0][OUT_W-1:0] main_data_q, main_data_d;
  logic [CHANNELS-1:0]            main_sat_q,  main_sat_d;
  logic                           main_vld_q,  main_vld_d;
  logic [CHANNELS-1:0][OUT_W-1:0] skid_data_q, skid_data_d;
  logic [CHANNELS-1:0]            skid_sat_q,  skid_sat_d;
  logic                           skid_full_q, skid_full_d;
  logic [CNT_W-1:0]               sat_cnt_q,   sat_cnt_d;

  logic in_fire;
  logic out_fire;

  assign in_fire  = bus.in_valid & ~skid_full_q;
  assign out_fire = main_vld_q & bus.out_ready;

  always_comb begin
    main_data_d = main_data_q;
    main_sat_d  = main_sat_q;
    main_vld_d  = main_vld_q;
    skid_data_d = skid_data_q;
    skid_sat_d  = skid_sat_q;
    skid_full_d = skid_full_q;
    sat_cnt_d   = sat_cnt_q;

    if (out_fire) begin
      if (skid_full_q) begin
        // in_ready was low, so no new beat competes with the skid drain.
        main_data_d = skid_data_q;
        main_sat_d  = skid_sat_q;
        skid_full_d = 1'b0;
      end else if (in_fire) begin
        main_data_d = conv_data;
        main_sat_d  = conv_sat;
      end else begin
        // Data/sat left as-is so out_data holds while out_valid is low.
        main_vld_d  = 1'b0;
      end
    end else if (in_fire) begin
      if (main_vld_q) begin
        skid_data_d = conv_data;
        skid_sat_d  = conv_sat;
        skid_full_d = 1'b1;
      end else begin
        main_data_d = conv_data;
        main_sat_d  = conv_sat;
        main_vld_d  = 1'b1;
      end
    end

    if (out_fire && (|main_sat_q) && (sat_cnt_q != '1)) begin
      sat_cnt_d = sat_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      main_data_q <= '0;
      main_sat_q  <= '0;
      main_vld_q  <= 1'b0;
      skid_data_q <= '0;
      skid_sat_q  <= '0;
      skid_full_q <= 1'b0;
      sat_cnt_q   <= '0;
    end else begin
      main_data_q <= main_data_d;
      main_sat_q  <= main_sat_d;
      main_vld_q  <= main_vld_d;
      skid_data_q <= skid_data_d;
      skid_sat_q  <= skid_sat_d;
      skid_full_q <= skid_full_d;
      sat_cnt_q   <= sat_cnt_d;
    end
  end

  assign bus.in_ready  = ~skid_full_q;
  assign bus.out_valid = main_vld_q;
  assign bus.out_data  = main_data_q;
  assign bus.out_sat   = main_sat_q;
  assign sat_count     = sat_cnt_q;

endmodule

// File: tb/tb_pad_ext_pipe.sv
// tb_pad_ext_pipe
//   Two converters share one stimulus stream: A widens 10->16 bits with a
//   16-bit counter, B narrows 10->8 bits with a 2-bit counter. The reference
//   is a depth-2 FIFO of expected beats whose values come from integer
//   arithmetic on the input lanes.
module tb_pad_ext_pipe;
  import pad_ext_pipe_pkg::*;

  localparam int CH  = 2;
  localparam int IW  = 10;
  localparam int OWA = 16;
  localparam int OWB = 8;
  localparam int CWA = 16;
  localparam int CWB = 2;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  logic              in_valid  = 1'b0;
  logic              out_ready = 1'b0;
  logic [CH*IW-1:0]  in_data   = '0;
  logic [1:0]        in_mode   = '0;

  pad_ext_pipe_if #(.CHANNELS(CH), .IN_W(IW), .OUT_W(OWA)) ifa ();
  pad_ext_pipe_if #(.CHANNELS(CH), .IN_W(IW), .OUT_W(OWB)) ifb ();

  assign ifa.in_valid  = in_valid;
  assign ifa.in_data   = in_data;
  assign ifa.in_mode   = pad_mode_e'(in_mode);
  assign ifa.out_ready = out_ready;
  assign ifb.in_valid  = in_valid;
  assign ifb.in_data   = in_data;
  assign ifb.in_mode   = pad_mode_e'(in_mode);
  assign ifb.out_ready = out_ready;

  logic [CWA-1:0] cnt_a;
  logic [CWB-1:0] cnt_b;

  pad_ext_pipe #(.CHANNELS(CH), .IN_W(IW), .OUT_W(OWA), .CNT_W(CWA)) dut_a (
    .clock(clock), .reset(rst_n), .bus(ifa), .sat_count(cnt_a));
  pad_ext_pipe #(.CHANNELS(CH), .IN_W(IW), .OUT_W(OWB), .CNT_W(CWB)) dut_b (
    .clock(clock), .reset(rst_n), .bus(ifb), .sat_count(cnt_b));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference conversion of one lane, straight from the numeric rules.
  function automatic void conv(input int ow, input logic [9:0] x, input logic [1:0] m,
                               output logic [15:0] y, output logic s);
    longint u, sv, v, lo, hi;
    u  = longint'(x);
    sv = x[9] ? u - 1024 : u;
    lo = -(longint'(1) << (ow - 1));
    hi = (longint'(1) << (ow - 1)) - 1;
    s  = 1'b0;
    if (m == 2'd1 || m == 2'd2) begin
      v = sv;
      if (sv < lo || sv > hi) begin
        s = 1'b1;
        if (m == 2'd2) v = (sv < lo) ? lo : hi;
      end
    end else begin
      v = u;
      s = (u > 2 * hi + 1);
    end
    y = 16'(v & ((longint'(1) << ow) - 1));
  endfunction

  typedef struct {
    logic [31:0] da;
    logic [1:0]  sa;
    logic [15:0] db;
    logic [1:0]  sb;
  } exp_t;

  function automatic exp_t mk(input logic [19:0] d, input logic [1:0] m);
    exp_t e;
    logic [15:0] y;
    logic s;
    for (int k = 0; k < CH; k++) begin
      conv(OWA, d[k*IW +: IW], m, y, s);
      e.da[k*16 +: 16] = y;
      e.sa[k] = s;
      conv(OWB, d[k*IW +: IW], m, y, s);
      e.db[k*8 +: 8] = y[7:0];
      e.sb[k] = s;
    end
    return e;
  endfunction

  exp_t        q[$];
  exp_t        cur;
  longint      ca, cb;
  logic [31:0] last_a;
  logic [15:0] last_b;
  logic        infire, outfire;

  // Compare process: outputs are checked against the FIFO model every cycle.
  always @(negedge clock) begin
    if (!rst_n) begin
      q.delete();
      ca = 0; cb = 0; last_a = '0; last_b = '0;
      chk("rst_in_ready_a",  ifa.in_ready,  1);
      chk("rst_out_valid_a", ifa.out_valid, 0);
      chk("rst_out_valid_b", ifb.out_valid, 0);
      chk("rst_cnt_b",       cnt_b,         0);
    end else begin
      chk("in_ready_a",  ifa.in_ready,  q.size() < 2);
      chk("in_ready_b",  ifb.in_ready,  q.size() < 2);
      chk("out_valid_a", ifa.out_valid, q.size() > 0);
      chk("out_valid_b", ifb.out_valid, q.size() > 0);
      if (q.size() > 0) begin
        chk("out_data_a", ifa.out_data, q[0].da);
        chk("out_sat_a",  ifa.out_sat,  q[0].sa);
        chk("out_data_b", ifb.out_data, q[0].db);
        chk("out_sat_b",  ifb.out_sat,  q[0].sb);
      end else begin
        chk("hold_data_a", ifa.out_data, last_a);
        chk("hold_data_b", ifb.out_data, last_b);
      end
      chk("sat_count_a", cnt_a, ca);
      chk("sat_count_b", cnt_b, cb);
      infire  = in_valid && (q.size() < 2);
      outfire = (q.size() > 0) && out_ready;
      if (outfire) begin
        cur = q.pop_front();
        if (|cur.sa && ca < 65535) ca++;
        if (|cur.sb && cb < 3) cb++;
        last_a = cur.da;
        last_b = cur.db;
      end
      if (infire) q.push_back(mk(in_data, in_mode));
    end
  end

  task automatic push(input logic [19:0] d, input logic [1:0] m);
    bit acc = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    for (int k = 0; k < 20 && !acc; k++) begin
      acc = ifa.in_ready;
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      tests++; fails++;
      $display("FAIL push_timeout: in_ready stayed 0, required 1");
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] y;
    logic s;
    // Pin the model with hand-computed values.
    conv(16, 10'h3E8, 2'd1, y, s); chk("model_sign16", {s, y}, {1'b0, 16'hFFE8});
    conv(16, 10'h3E8, 2'd3, y, s); chk("model_rsvd16", {s, y}, {1'b0, 16'h03E8});
    conv(8,  10'h1F4, 2'd2, y, s); chk("model_clamp8", {s, y}, {1'b1, 16'h007F});
    conv(8,  10'h3F0, 2'd2, y, s); chk("model_neg8",   {s, y}, {1'b0, 16'h00F0});

    repeat (2) @(posedge clock);
    #1 rst_n = 1'b1;
    chk("init_in_ready", ifa.in_ready, 1);
    out_ready = 1'b1;

    // Zero extend, then sign extend and reserved mode.
    push({10'h001, 10'h3E8}, 2'd0);
    chk("t1_valid", ifa.out_valid, 1);
    chk("t1_data",  ifa.out_data, 32'h0001_03E8);
    chk("t1_sat",   ifa.out_sat, 2'b00);
    push({10'h001, 10'h3E8}, 2'd1);
    chk("t2_sign",  ifa.out_data[15:0], 16'hFFE8);
    push({10'h001, 10'h3E8}, 2'd3);
    chk("t2_rsvd",  ifa.out_data[15:0], 16'h03E8);
    @(posedge clock); #1;
    do_reset();

    // Signed saturate on the narrowing instance.
    push({10'h3F0, 10'h1F4}, 2'd2);
    chk("t3_data_b", ifb.out_data, 16'hF07F);
    chk("t3_sat_b",  ifb.out_sat, 2'b01);
    @(posedge clock); #1;
    chk("t3_cnt_b",  cnt_b, 1);

    // Counter saturation at 2^CNT_W-1.
    for (int i = 0; i < 5; i++) push({10'h000, 10'h1F4}, 2'd2);
    repeat (2) @(posedge clock); #1;
    chk("t5_cnt_b_hold", cnt_b, 3);

    // Backpressure: skid fills after beat 2, then drains in order.
    push(20'h00011, 2'd0);
    out_ready = 1'b0;
    push(20'h00022, 2'd1);
    chk("t4_in_ready_low", ifa.in_ready, 0);
    repeat (2) @(posedge clock); #1;
    chk("t4_still_low", ifa.in_ready, 0);
    chk("t4_head", ifa.out_data, 32'h0000_0011);
    out_ready = 1'b1;
    push(20'h00033, 2'd2);
    push(20'h00044, 2'd0);
    repeat (3) @(posedge clock); #1;

    // Async reset with both registers occupied.
    out_ready = 1'b0;
    push({10'h000, 10'h1F4}, 2'd2);
    push({10'h000, 10'h1F4}, 2'd2);
    chk("t6_full", ifa.in_ready, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_valid_a", ifa.out_valid, 0);
    chk("t6_valid_b", ifb.out_valid, 0);
    chk("t6_cnt_b",   cnt_b, 0);
    chk("t6_ready",   ifa.in_ready, 1);
    repeat (2) @(posedge clock);
    #1 rst_n = 1'b1;
    chk("t6_ready_after", ifa.in_ready, 1);
    out_ready = 1'b1;
    repeat (4) @(posedge clock); #1;
    chk("t6_no_stale", ifa.out_valid, 0);

    // Randomised traffic with varying backpressure.
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = 20'($urandom);
      in_mode   = 2'($urandom_range(0, 3));
      out_ready = (i % 300 < 150) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
      @(posedge clock); #1;
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clock); #1;
    chk("drain_empty_a", ifa.out_valid, 0);
    chk("drain_empty_b", ifb.out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
